led_pattern_gen: RTL and testbench



---
 rtl/led_pattern_gen.sv | 178 +++++++++++++++++
 tb/tb_led_pattern_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a free-running prescaler steps COUNT / SCAN / BREATHE / HOLD patterns.
// Define LED_PWM_EN to compile in BREATHE mode; without it, mode 2'b10 behaves exactly as HOLD.
module led_pattern_gen #(
    parameter int NLEDS    = 5,
    parameter int SLOW     = 19,
    parameter int PWM_BITS = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       mode,
    output logic [NLEDS-1:0] leds,
    output logic             tick
);
    localparam logic [1:0] MODE_COUNT   = 2'b00;
    localparam logic [1:0] MODE_SCAN    = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    logic [SLOW-1:0]  pre_reg;
    logic             tick_reg;
    logic [1:0]       cur_mode_reg;
    logic [NLEDS-1:0] leds_reg, leds_next;
    logic [NLEDS-1:0] cnt_reg, cnt_next;
    logic [NLEDS-1:0] pos_reg, pos_next;
    logic             dir_reg, dir_next;
    logic             wrap;

    assign wrap = &pre_reg;
    assign leds = leds_reg;
    assign tick = tick_reg;

    function automatic logic is_hold(input logic [1:0] m);
`ifdef LED_PWM_EN
        return m == MODE_HOLD;
`else
        return (m == MODE_HOLD) || (m == MODE_BREATHE);
`endif
    endfunction

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_reg;
    logic [PWM_BITS-1:0] level_reg, level_next;
    logic                rising_reg, rising_next;
    logic                pwm_on;
    logic [NLEDS-1:0]    pwm_bus;

    assign pwm_on = pwm_reg < level_reg;
    for (genvar gi = 0; gi < NLEDS; gi++) begin : g_pwm_bus
        assign pwm_bus[gi] = pwm_on;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_reg    <= '0;
            level_reg  <= '0;
            rising_reg <= 1'b1;
        end else begin
            pwm_reg    <= pwm_reg + PWM_BITS'(1);
            level_reg  <= level_next;
            rising_reg <= rising_next;
        end
    end
`else
    // PWM_BITS has no effect without BREATHE.
    localparam int unused_pwm_bits = PWM_BITS;
`endif

    always_comb begin
        leds_next = leds_reg;
        cnt_next  = cnt_reg;
        pos_next  = pos_reg;
        dir_next  = dir_reg;
`ifdef LED_PWM_EN
        level_next  = level_reg;
        rising_next = rising_reg;
`endif
        if (wrap) begin
            if (mode != cur_mode_reg) begin
                // Entering a new non-HOLD mode restarts it; entering HOLD keeps everything.
                if (!is_hold(mode)) begin
                    case (mode)
                        MODE_COUNT: begin
                            cnt_next  = NLEDS'(1);
                            leds_next = NLEDS'(1);
                        end
                        MODE_SCAN: begin
                            pos_next  = NLEDS'(1);
                            dir_next  = 1'b1;
                            leds_next = NLEDS'(1);
                        end
                        default: begin
`ifdef LED_PWM_EN
                            level_next  = '0;
                            rising_next = 1'b1;
                            leds_next   = '0;
`endif
                        end
                    endcase
                end
            end else if (!is_hold(cur_mode_reg)) begin
                case (cur_mode_reg)
                    MODE_COUNT: begin
                        cnt_next  = cnt_reg + NLEDS'(1);
                        leds_next = cnt_next;
                    end
                    MODE_SCAN: begin
                        // Direction flips as the endpoint is left, so each end shows once.
                        if (NLEDS == 1) begin
                            pos_next = pos_reg;
                        end else if (dir_reg) begin
                            if (pos_reg[NLEDS-1]) begin
                                pos_next = pos_reg >> 1;
                                dir_next = 1'b0;
                            end else begin
                                pos_next = pos_reg << 1;
                            end
                        end else begin
                            if (pos_reg[0]) begin
                                pos_next = pos_reg << 1;
                                dir_next = 1'b1;
                            end else begin
                                pos_next = pos_reg >> 1;
                            end
                        end
                        leds_next = pos_next;
                    end
                    default: begin
`ifdef LED_PWM_EN
                        if (rising_reg) begin
                            if (&level_reg) begin
                                level_next  = level_reg - PWM_BITS'(1);
                                rising_next = 1'b0;
                            end else begin
                                level_next = level_reg + PWM_BITS'(1);
                            end
                        end else begin
                            if (level_reg == '0) begin
                                level_next  = level_reg + PWM_BITS'(1);
                                rising_next = 1'b1;
                            end else begin
                                level_next = level_reg - PWM_BITS'(1);
                            end
                        end
                        leds_next = pwm_bus;
`endif
                    end
                endcase
            end
        end
`ifdef LED_PWM_EN
        else if (cur_mode_reg == MODE_BREATHE) begin
            leds_next = pwm_bus;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_reg      <= '0;
            tick_reg     <= 1'b0;
            cur_mode_reg <= MODE_COUNT;
            leds_reg     <= '0;
            cnt_reg      <= '0;
            pos_reg      <= NLEDS'(1);
            dir_reg      <= 1'b1;
        end else begin
            pre_reg  <= pre_reg + SLOW'(1);
            tick_reg <= wrap;
            if (wrap) begin
                cur_mode_reg <= mode;
            end
            leds_reg <= leds_next;
            cnt_reg  <= cnt_next;
            pos_reg  <= pos_next;
            dir_reg  <= dir_next;
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (NLEDS=5, SLOW=2, PWM_BITS=3); follows LED_PWM_EN like the DUT.
module tb_led_pattern_gen;
    localparam int NLEDS    = 5;
    localparam int SLOW     = 2;
    localparam int PWM_BITS = 3;
    localparam int PERIOD   = 1 << SLOW;
`ifdef LED_PWM_EN
    localparam bit PWM_EN = 1'b1;
`else
    localparam bit PWM_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [NLEDS-1:0] leds;
    logic             tick;

    led_pattern_gen #(.NLEDS(NLEDS), .SLOW(SLOW), .PWM_BITS(PWM_BITS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mode   (mode),
        .leds   (leds),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model: pattern position tracked as a tick index, patterns derived arithmetically.
    int               n;
    int               m_cur;
    int               m_cnt;
    int               m_sk;
    int               m_bk;
    logic [NLEDS-1:0] m_leds;
    logic             m_tick;

    typedef struct {
        int               m;
        logic [NLEDS-1:0] exp_leds;
        logic             exp_tick;
    } vec_t;

    function automatic bit is_hold(input int m);
        return (m == 3) || (m == 2 && !PWM_EN);
    endfunction

    function automatic logic [NLEDS-1:0] scan_pat(input int k);
        int i;
        int p;
        i = k % (2 * NLEDS - 2);
        p = (i < NLEDS) ? i : (2 * NLEDS - 2 - i);
        return NLEDS'(1) << p;
    endfunction

    function automatic int level_of(input int k);
        int top;
        int i;
        top = (1 << PWM_BITS) - 1;
        i = k % (2 * top);
        return (i <= top) ? i : (2 * top - i);
    endfunction

    task automatic model_reset();
        n = 0; m_cur = 0; m_cnt = 0; m_sk = 0; m_bk = 0;
        m_leds = '0; m_tick = 1'b0;
    endtask

    task automatic model_edge(input int m);
        int pwm;
        bit wrap;
        bit on;
        pwm = n % (1 << PWM_BITS);
        n++;
        wrap = (n % PERIOD) == 0;
        on = pwm < level_of(m_bk);
        m_tick = wrap;
        if (wrap) begin
            if (m != m_cur) begin
                m_cur = m;
                if (!is_hold(m)) begin
                    case (m)
                        0: begin m_cnt = 1; m_leds = NLEDS'(m_cnt); end
                        1: begin m_sk = 0; m_leds = scan_pat(m_sk); end
                        default: begin m_bk = 0; m_leds = '0; end
                    endcase
                end
            end else if (!is_hold(m_cur)) begin
                case (m_cur)
                    0: begin m_cnt = (m_cnt + 1) % (1 << NLEDS); m_leds = NLEDS'(m_cnt); end
                    1: begin m_sk++; m_leds = scan_pat(m_sk); end
                    default: begin m_leds = {NLEDS{on}}; m_bk++; end
                endcase
            end
        end else if (m_cur == 2 && PWM_EN) begin
            m_leds = {NLEDS{on}};
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int m, input string name);
        mode = 2'(m);
        @(posedge clk);
        model_edge(m);
        #1;
        $display("[TB] %s mode=%0d leds=%b tick=%b", name, m, leds, tick);
        check({name, "_leds"}, 32'(leds), 32'(m_leds));
        check({name, "_tick"}, 32'(tick), 32'(m_tick));
    endtask

    task automatic run_to_tick(input int m, input string name);
        bit got;
        got = 1'b0;
        for (int j = 0; j < PERIOD && !got; j++) begin
            step(m, name);
            got = m_tick;
        end
        if (!got) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_no_tick: got no tick, expected one within %0d clks", name, PERIOD);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             count_vec[12];
        logic [NLEDS-1:0] scan_exp[10];
        int               rm;

        count_vec = '{
            '{0, 5'd0, 1'b0}, '{0, 5'd0, 1'b0}, '{0, 5'd0, 1'b0}, '{0, 5'd1, 1'b1},
            '{0, 5'd1, 1'b0}, '{0, 5'd1, 1'b0}, '{0, 5'd1, 1'b0}, '{0, 5'd2, 1'b1},
            '{0, 5'd2, 1'b0}, '{0, 5'd2, 1'b0}, '{0, 5'd2, 1'b0}, '{0, 5'd3, 1'b1}
        };
        scan_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                     5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00010};

        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_leds", 32'(leds), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(count_vec[i].m, "count_vec");
            check("count_vec_leds_tbl", 32'(leds), 32'(count_vec[i].exp_leds));
            check("count_vec_tick_tbl", 32'(tick), 32'(count_vec[i].exp_tick));
        end

        for (int i = 0; i < 29 * PERIOD; i++) step(0, "count_run");
        check("count_wrap_zero", 32'(leds), 32'd0);

        step(0, "scan_pre");
        step(0, "scan_pre");
        for (int t = 0; t < 10; t++) begin
            run_to_tick(1, "scan");
            check("scan_seq", 32'(leds), 32'(scan_exp[t]));
        end

        run_to_tick(1, "scan_to_hold");
        check("hold_start", 32'(leds), 32'b00100);
        for (int t = 0; t < 20; t++) begin
            run_to_tick(3, "hold");
            check("hold_frozen", 32'(leds), 32'b00100);
        end
        run_to_tick(1, "hold_exit");
        check("hold_exit_scan", 32'(leds), 32'b00001);

`ifdef LED_PWM_EN
        run_to_tick(2, "breathe_entry");
        for (int j = 0; j < PERIOD; j++) begin
            step(2, "breathe_dark");
            check("breathe_level0_dark", 32'(leds), 32'd0);
        end
        for (int j = 0; j < 16 * PERIOD; j++) step(2, "breathe");
`endif

        for (int t = 0; t < 7; t++) run_to_tick(0, "count_to7");
        check("count_at7", 32'(leds), 32'd7);
        #1 resetn = 1'b0;
        #1;
        check("async_rst_leds", 32'(leds), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        model_reset();
        #1 resetn = 1'b1;
        for (int j = 0; j < PERIOD; j++) begin
            step(0, "post_rst");
            check("post_rst_tick_at4", 32'(tick), 32'(j == PERIOD - 1));
        end

`ifndef LED_PWM_EN
        for (int t = 0; t < 8; t++) run_to_tick(0, "count_to9");
        check("count_at9", 32'(leds), 32'd9);
        for (int t = 0; t < 10; t++) begin
            run_to_tick(2, "nopwm_hold");
            check("nopwm_frozen", 32'(leds), 32'd9);
            check("nopwm_tick", 32'(tick), 32'd1);
        end
`endif

        rm = 0;
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 5) == 0) rm = int'($urandom_range(0, 3));
            step(rm, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
